// File: rtl/lcd_pkg.sv
// Shared LCD definitions: controller opcodes, sequencer state encoding, opcode helpers.
package lcd_pkg;

  localparam logic [3:0] OP_WRITE    = 4'd0;
  localparam logic [3:0] OP_UP       = 4'd1;
  localparam logic [3:0] OP_DOWN     = 4'd2;
  localparam logic [3:0] OP_LEFT     = 4'd3;
  localparam logic [3:0] OP_RIGHT    = 4'd4;
  localparam logic [3:0] OP_MAX      = 4'd5;
  localparam logic [3:0] OP_MIN      = 4'd6;
  localparam logic [3:0] OP_AVG      = 4'd7;
  localparam logic [3:0] OP_CCROTATE = 4'd8;
  localparam logic [3:0] OP_CROTATE  = 4'd9;
  localparam logic [3:0] OP_MIRRORX  = 4'd10;
  localparam logic [3:0] OP_MIRRORY  = 4'd11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_ACK,
    S_EXEC,
    S_NEXT,
    S_FINISH
  } seq_state_e;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > OP_MIRRORY;
  endfunction

  // States that wait on the LCD controller and may therefore stall forever.
  function automatic logic state_is_watched(input seq_state_e s);
    return (s == S_INIT) || (s == S_ISSUE) || (s == S_ACK) || (s == S_EXEC);
  endfunction

endpackage

// File: rtl/lcd_seq_wdog.sv
// Per-state stall watchdog: counts cycles spent in the current state, fires at WDOG_MAX in a waiting state.
module lcd_seq_wdog
  import lcd_pkg::*;
#(
  parameter int WDOG_MAX = 255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  seq_state_e state_i,
  output logic       fire_o
);

  seq_state_e prev_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] cur;

  // The count restarts at zero in the first cycle of every new state.
  always_comb begin
    cur   = (state_i != prev_q) ? 8'd0 : cnt_q;
    cnt_d = (cur == 8'hFF) ? cur : cur + 8'd1;
  end

  assign fire_o = state_is_watched(state_i) && (cur == 8'(WDOG_MAX));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= S_IDLE;
      cnt_q  <= 8'd0;
    end else begin
      prev_q <= state_i;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Script-ROM driven command scheduler for the LCD controller, one command in flight at a time.
// Optional stall watchdog compiled in with SEQ_WATCHDOG_EN; otherwise timeout is constant 0.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int SCR_AW   = 5,
  parameter int WDOG_MAX = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              scr_rd,
  output logic [SCR_AW-1:0] scr_A,
  input  logic [4:0]        scr_Q,
  output logic [3:0]        lcd_cmd,
  output logic              lcd_cmd_valid,
  input  logic              lcd_busy,
  input  logic              lcd_done,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              illegal,
  output logic              timeout,
  output logic [7:0]        cmd_cnt
);

  localparam logic [SCR_AW-1:0] ADDR_LAST = '1;

  seq_state_e        state_q;
  logic              scr_rd_q;
  logic [SCR_AW-1:0] scr_a_q;
  logic [3:0]        op_q;
  logic              last_q;
  logic [3:0]        cmd_q;
  logic              cmd_vld_q;
  logic              busy_q;
  logic              done_q;
  logic              illegal_q;
  logic              timeout_q;
  logic [7:0]        cnt_q;
  logic              wdog_fire;

`ifdef SEQ_WATCHDOG_EN
  lcd_seq_wdog #(
    .WDOG_MAX(WDOG_MAX)
  ) u_wdog (
    .clk_i  (clk),
    .rst_ni (reset),
    .state_i(state_q),
    .fire_o (wdog_fire)
  );
`else
  logic wdog_unused;
  assign wdog_unused = (WDOG_MAX != 0);
  assign wdog_fire   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      scr_rd_q  <= 1'b0;
      scr_a_q   <= '0;
      op_q      <= 4'd0;
      last_q    <= 1'b0;
      cmd_q     <= 4'd0;
      cmd_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      scr_rd_q  <= 1'b0;
      cmd_vld_q <= 1'b0;
      if (wdog_fire) begin
        timeout_q <= 1'b1;
        state_q   <= S_FINISH;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q   <= S_INIT;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              cnt_q     <= 8'd0;
              illegal_q <= 1'b0;
              timeout_q <= 1'b0;
              scr_a_q   <= '0;
            end
          end
          S_INIT: begin
            if (!lcd_busy) begin
              state_q  <= S_FETCH;
              scr_rd_q <= 1'b1;
            end
          end
          S_FETCH: state_q <= S_LATCH;
          S_LATCH: begin
            op_q   <= scr_Q[3:0];
            last_q <= scr_Q[4];
            if (op_is_illegal(scr_Q[3:0])) begin
              illegal_q <= 1'b1;
              state_q   <= S_NEXT;
            end else begin
              state_q <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (!lcd_busy) begin
              cmd_q     <= op_q;
              cmd_vld_q <= 1'b1;
              if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
              state_q   <= S_ACK;
            end
          end
          // Busy seen alongside the strobe is not an acknowledge; it must persist a cycle.
          S_ACK: begin
            if (lcd_busy && !cmd_vld_q) state_q <= S_EXEC;
          end
          S_EXEC: begin
            if (op_q == OP_WRITE) begin
              if (lcd_done) state_q <= S_FINISH;
            end else if (!lcd_busy) begin
              state_q <= S_NEXT;
            end
          end
          S_NEXT: begin
            if (last_q || (scr_a_q == ADDR_LAST)) begin
              state_q <= S_FINISH;
            end else begin
              scr_a_q  <= scr_a_q + 1'b1;
              scr_rd_q <= 1'b1;
              state_q  <= S_FETCH;
            end
          end
          S_FINISH: begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign scr_rd        = scr_rd_q;
  assign scr_A         = scr_a_q;
  assign lcd_cmd       = cmd_q;
  assign lcd_cmd_valid = cmd_vld_q;
  assign seq_busy      = busy_q;
  assign seq_done      = done_q;
  assign illegal       = illegal_q;
  assign timeout       = timeout_q;
  assign cmd_cnt       = cnt_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer: script ROM and LCD controller models plus a script-level reference.
module tb_lcd_cmd_sequencer;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       scr_rd;
  logic [4:0] scr_A;
  logic [4:0] scr_Q = 5'd0;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy = 1'b0;
  logic       lcd_done = 1'b0;
  logic       seq_busy, seq_done, illegal, timeout;
  logic [7:0] cmd_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  logic [4:0] rom [DEPTH];
  int   exp_cmd[$];
  int   exp_fa[$];
  int   issued = 0;
  logic hang = 1'b0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  lcd_cmd_sequencer #(.SCR_AW(5), .WDOG_MAX(255)) dut (
    .clk(clk), .reset(reset), .start(start),
    .scr_rd(scr_rd), .scr_A(scr_A), .scr_Q(scr_Q),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid),
    .lcd_busy(lcd_busy), .lcd_done(lcd_done),
    .seq_busy(seq_busy), .seq_done(seq_done), .illegal(illegal),
    .timeout(timeout), .cmd_cnt(cmd_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Script ROM: one-cycle read latency.
  always @(posedge clk) begin
    logic       rd;
    logic [4:0] a;
    rd = scr_rd;
    a  = scr_A;
    #1;
    if (rd) scr_Q = rom[a];
  end

  // LCD controller: busy for 2 cycles per command, done pulse 70 cycles after a write.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      busy_cnt = 0; done_cnt = 0; lcd_busy = 1'b0; lcd_done = 1'b0;
    end else begin
      lcd_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) lcd_done = 1'b1;
      end
      if (lcd_cmd_valid) begin
        busy_cnt = 2;
        if (lcd_cmd == 4'd0) done_cnt = 70;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      lcd_busy = hang ? (lcd_busy | lcd_cmd_valid) : (busy_cnt > 0);
    end
  end

  // Compare process: every fetch and every issued command against the reference.
  always @(negedge clk) begin
    if (reset) begin
      if (scr_rd) begin
        if (exp_fa.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_fetch: got addr %0d, expected no fetch", scr_A);
        end else chk("fetch_addr", scr_A, exp_fa.pop_front());
      end
      if (lcd_cmd_valid) begin
        issued++;
        if (exp_cmd.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_cmd: got opcode %0d, expected no command", lcd_cmd);
        end else chk("cmd", lcd_cmd, exp_cmd.pop_front());
        chk("cmd_cnt_live", cmd_cnt, (issued > 255) ? 255 : issued);
      end
    end
  end

  // Script-level reference: walk the ROM, skip illegal opcodes, stop on write, last flag or end of ROM.
  task automatic build_model(input logic hang_mode, output int n_cmd, output int last_a,
                             output logic ill);
    int op;
    exp_cmd.delete();
    exp_fa.delete();
    ill    = 1'b0;
    last_a = 0;
    for (int a = 0; a < DEPTH; a++) begin
      exp_fa.push_back(a);
      last_a = a;
      op = int'(rom[a][3:0]);
      if (op >= 12) ill = 1'b1;
      else begin
        exp_cmd.push_back(op);
        if (op == 0 || hang_mode) break;
      end
      if (rom[a][4]) break;
    end
    n_cmd = exp_cmd.size();
  endtask

  task automatic run_script(input string tag, input logic hang_mode, input int extra_start_at,
                            input int budget, output int n_cmd, output int last_a);
    logic ill;
    logic got;
    hang = hang_mode;
    build_model(hang_mode, n_cmd, last_a, ill);
    issued = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy_on_start"}, seq_busy, 1);
    chk({tag, "_done_cleared"}, seq_done, 0);
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      start = (k == extra_start_at);
      @(negedge clk);
      if (seq_done) begin got = 1'b1; break; end
    end
    start = 1'b0;
    chk({tag, "_finished"}, got, 1);
    chk({tag, "_cmd_cnt"}, cmd_cnt, n_cmd);
    chk({tag, "_illegal"}, illegal, ill);
    chk({tag, "_scr_A"}, scr_A, last_a);
    chk({tag, "_seq_busy"}, seq_busy, 0);
    chk({tag, "_timeout"}, timeout, hang_mode);
    chk({tag, "_cmds_left"}, exp_cmd.size(), 0);
    chk({tag, "_fetches_left"}, exp_fa.size(), 0);
  endtask

  task automatic fill_rom(input logic [4:0] fill);
    for (int a = 0; a < DEPTH; a++) rom[a] = fill;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int   nc, la, v;
    logic hit;

    fill_rom(5'h10);
    repeat (3) @(negedge clk);
    chk("rst_scr_rd", scr_rd, 0);
    chk("rst_scr_A", scr_A, 0);
    chk("rst_lcd_cmd", lcd_cmd, 0);
    chk("rst_valid", lcd_cmd_valid, 0);
    chk("rst_seq_busy", seq_busy, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cmd_cnt", cmd_cnt, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 4, 2, 5, write|last
    fill_rom(5'h10);
    rom[0] = 5'h04; rom[1] = 5'h02; rom[2] = 5'h05; rom[3] = 5'h10;
    run_script("basic", 1'b0, -1, 400, nc, la);
    chk("basic_cnt_lit", cmd_cnt, 4);
    chk("basic_addr_lit", scr_A, 3);
    chk("basic_done_lit", seq_done, 1);

    // 1, illegal 13, 9|last
    fill_rom(5'h10);
    rom[0] = 5'h01; rom[1] = 5'h0D; rom[2] = 5'h19;
    run_script("illegal", 1'b0, -1, 300, nc, la);
    chk("illegal_cnt_lit", cmd_cnt, 2);
    chk("illegal_flag_lit", illegal, 1);

    // full ROM, no last flag
    fill_rom(5'h03);
    run_script("full", 1'b0, -1, 1000, nc, la);
    chk("full_cnt_lit", cmd_cnt, 32);
    chk("full_addr_lit", scr_A, 31);

    // write in the middle terminates the script
    fill_rom(5'h03);
    rom[0] = 5'h07; rom[1] = 5'h00;
    run_script("midwrite", 1'b0, -1, 400, nc, la);
    chk("midwrite_cnt_lit", cmd_cnt, 2);
    chk("midwrite_addr_lit", scr_A, 1);

    // lone illegal entry with last flag
    fill_rom(5'h10);
    rom[0] = 5'h1C;
    run_script("only_illegal", 1'b0, -1, 100, nc, la);
    chk("only_illegal_cnt_lit", cmd_cnt, 0);

    // start pulsed while running
    fill_rom(5'h10);
    rom[0] = 5'h04; rom[1] = 5'h02; rom[2] = 5'h05; rom[3] = 5'h10;
    run_script("restart_ignored", 1'b0, 6, 400, nc, la);
    chk("restart_cnt_lit", cmd_cnt, 4);

    // reset during EXEC of the second command
    build_model(1'b0, nc, la, hit);
    issued = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    v = 0; hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (lcd_cmd_valid) v++;
      if (v == 2) begin hit = 1'b1; break; end
    end
    chk("rst_run_reached_2nd", hit, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_scr_rd", scr_rd, 0);
    chk("midrst_scr_A", scr_A, 0);
    chk("midrst_lcd_cmd", lcd_cmd, 0);
    chk("midrst_valid", lcd_cmd_valid, 0);
    chk("midrst_seq_busy", seq_busy, 0);
    chk("midrst_seq_done", seq_done, 0);
    chk("midrst_cmd_cnt", cmd_cnt, 0);
    exp_cmd.delete();
    exp_fa.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle_busy", seq_busy, 0);
    chk("post_rst_idle_cnt", cmd_cnt, 0);
    run_script("rerun", 1'b0, -1, 400, nc, la);
    chk("rerun_cnt_lit", cmd_cnt, 4);

`ifdef SEQ_WATCHDOG_EN
    // LCD never drops busy after the first command
    run_script("wdog", 1'b1, -1, 700, nc, la);
    chk("wdog_cnt_lit", cmd_cnt, 1);
    chk("wdog_timeout_lit", timeout, 1);
    reset = 1'b0;
    hang  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
